// File: rtl/transform_scheduler.sv
// Frame-level sequencer: fetches draw commands, requests model loads on cache
// misses, starts the transform pipeline per draw and tallies draws/triangles.
module transform_scheduler #(
    parameter int MODEL_ID_WIDTH   = 4,
    parameter int DRAW_COUNT_WIDTH = 8,
    parameter int TRI_COUNT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES   = 1048576
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_frame_start,
    output logic                        o_ready,
    output logic                        o_frame_done,
    input  logic                        i_cmd_valid,
    output logic                        o_cmd_ready,
    input  logic [MODEL_ID_WIDTH-1:0]   i_cmd_model_id,
    input  logic                        i_cmd_last,
    output logic [MODEL_ID_WIDTH-1:0]   o_model_select,
    output logic                        o_model_load,
    input  logic                        i_model_loaded,
    output logic                        o_tp_start,
    input  logic                        i_tp_ready,
    input  logic                        i_tp_done,
    input  logic                        i_triangle_dv,
    output logic [DRAW_COUNT_WIDTH-1:0] o_draw_count,
    output logic [TRI_COUNT_WIDTH-1:0]  o_triangle_count,
    output logic                        o_timeout
);

    localparam int WD_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_CMD,
        LOAD_MODEL,
        WAIT_LOAD,
        START_TP,
        WAIT_TP,
        FRAME_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [MODEL_ID_WIDTH-1:0]   model_select_q, model_select_d;
    logic                        loaded_valid_q, loaded_valid_d;
    logic                        last_q, last_d;
    logic [DRAW_COUNT_WIDTH-1:0] draw_count_q, draw_count_d;
    logic [TRI_COUNT_WIDTH-1:0]  tri_count_q, tri_count_d;
    logic                        timeout_q, timeout_d;
    logic [WD_WIDTH-1:0]         wd_q, wd_d;
    logic [WD_WIDTH-1:0]         wd_next;

    always_comb begin
        state_d        = state_q;
        model_select_d = model_select_q;
        loaded_valid_d = loaded_valid_q;
        last_d         = last_q;
        draw_count_d   = draw_count_q;
        tri_count_d    = tri_count_q;
        timeout_d      = timeout_q;
        wd_d           = wd_q;
        wd_next        = wd_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (i_frame_start) begin
                    draw_count_d = '0;
                    tri_count_d  = '0;
                    timeout_d    = 1'b0;
                    state_d      = FETCH_CMD;
                end
            end
            FETCH_CMD: begin
                if (i_cmd_valid) begin
                    last_d = i_cmd_last;
                    if (loaded_valid_q && (i_cmd_model_id == model_select_q)) begin
                        state_d = START_TP;
                    end else begin
                        model_select_d = i_cmd_model_id;
                        loaded_valid_d = 1'b0;
                        state_d        = LOAD_MODEL;
                    end
                end
            end
            LOAD_MODEL: state_d = WAIT_LOAD;
            WAIT_LOAD: begin
                if (i_model_loaded) begin
                    loaded_valid_d = 1'b1;
                    state_d        = START_TP;
                end
            end
            START_TP: begin
                if (i_tp_ready) begin
                    wd_d    = '0;
                    state_d = WAIT_TP;
                end
            end
            WAIT_TP: begin
                // Done takes priority over a watchdog expiry in the same cycle.
                if (i_tp_done) begin
                    draw_count_d = draw_count_q + 1'b1;
                    state_d      = last_q ? FRAME_DONE : FETCH_CMD;
                end else if (wd_next == WD_LAST) begin
                    timeout_d      = 1'b1;
                    loaded_valid_d = 1'b0;
                    state_d        = FRAME_DONE;
                end else begin
                    wd_d = wd_next;
                end
            end
            FRAME_DONE: state_d = IDLE;
            default:    state_d = IDLE;
        endcase

        if ((state_q != IDLE) && i_triangle_dv && (tri_count_q != '1)) begin
            tri_count_d = tri_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            model_select_q <= '0;
            loaded_valid_q <= 1'b0;
            last_q         <= 1'b0;
            draw_count_q   <= '0;
            tri_count_q    <= '0;
            timeout_q      <= 1'b0;
            wd_q           <= '0;
        end else begin
            state_q        <= state_d;
            model_select_q <= model_select_d;
            loaded_valid_q <= loaded_valid_d;
            last_q         <= last_d;
            draw_count_q   <= draw_count_d;
            tri_count_q    <= tri_count_d;
            timeout_q      <= timeout_d;
            wd_q           <= wd_d;
        end
    end

    assign o_ready          = (state_q == IDLE);
    assign o_cmd_ready      = (state_q == FETCH_CMD);
    assign o_model_load     = (state_q == LOAD_MODEL);
    assign o_frame_done     = (state_q == FRAME_DONE);
    assign o_tp_start       = (state_q == START_TP) && i_tp_ready;
    assign o_model_select   = model_select_q;
    assign o_draw_count     = draw_count_q;
    assign o_triangle_count = tri_count_q;
    assign o_timeout        = timeout_q;

endmodule

// File: tb/tb_transform_scheduler.sv
// Scoreboard bench for transform_scheduler: a frame-level model predicts model
// loads, pipeline starts and end-of-frame counters; a monitor checks them.
module tb_transform_scheduler;

    localparam int MW      = 4;
    localparam int DW      = 8;
    localparam int TW      = 16;
    localparam int TO      = 16;
    localparam int TRI_MAX = (1 << TW) - 1;

    logic          clk;
    logic          rst;
    logic          i_frame_start;
    logic          o_ready;
    logic          o_frame_done;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [MW-1:0] i_cmd_model_id;
    logic          i_cmd_last;
    logic [MW-1:0] o_model_select;
    logic          o_model_load;
    logic          i_model_loaded;
    logic          o_tp_start;
    logic          i_tp_ready;
    logic          i_tp_done;
    logic          i_triangle_dv;
    logic [DW-1:0] o_draw_count;
    logic [TW-1:0] o_triangle_count;
    logic          o_timeout;

    transform_scheduler #(
        .MODEL_ID_WIDTH  (MW),
        .DRAW_COUNT_WIDTH(DW),
        .TRI_COUNT_WIDTH (TW),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_frame_start   (i_frame_start),
        .o_ready         (o_ready),
        .o_frame_done    (o_frame_done),
        .i_cmd_valid     (i_cmd_valid),
        .o_cmd_ready     (o_cmd_ready),
        .i_cmd_model_id  (i_cmd_model_id),
        .i_cmd_last      (i_cmd_last),
        .o_model_select  (o_model_select),
        .o_model_load    (o_model_load),
        .i_model_loaded  (i_model_loaded),
        .o_tp_start      (o_tp_start),
        .i_tp_ready      (i_tp_ready),
        .i_tp_done       (i_tp_done),
        .i_triangle_dv   (i_triangle_dv),
        .o_draw_count    (o_draw_count),
        .o_triangle_count(o_triangle_count),
        .o_timeout       (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int draws;
        int tris;
        bit timedOut;
    } frameExp_t;

    logic [MW-1:0] loadQ[$];
    logic [MW-1:0] tpQ[$];
    frameExp_t     frameQ[$];

    // Reference cache state: which model the buffer currently holds, if any.
    bit            cacheValid = 1'b0;
    logic [MW-1:0] cacheId    = '0;

    // Current frame description consumed by applyStimulus.
    int            frmN;
    logic [MW-1:0] frmIds[8];
    int            frmDelay[8];
    logic [31:0]   frmDv[8];
    int            frmTpLow;
    int            frmSat;

    logic [MW-1:0] monId;
    frameExp_t     monF;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got no matching event, expected one", name);
    endtask

    // Monitor: every output pulse must match the head of its expectation queue.
    always @(negedge clk) begin
        #2;
        if (o_model_load === 1'b1) begin
            if (loadQ.size() == 0) begin
                failNow("unexpected_model_load");
            end else begin
                monId = loadQ.pop_front();
                checkOutput("load_model_select", o_model_select, monId);
            end
        end
        if (o_tp_start === 1'b1) begin
            if (tpQ.size() == 0) begin
                failNow("unexpected_tp_start");
            end else begin
                monId = tpQ.pop_front();
                checkOutput("tp_start_model_select", o_model_select, monId);
            end
        end
        if (o_frame_done === 1'b1) begin
            if (frameQ.size() == 0) begin
                failNow("unexpected_frame_done");
            end else begin
                monF = frameQ.pop_front();
                checkOutput("frame_draw_count", o_draw_count, monF.draws);
                checkOutput("frame_triangle_count", o_triangle_count, monF.tris);
                checkOutput("frame_timeout", o_timeout, monF.timedOut);
            end
        end
    end

    task automatic clearInputs();
        i_frame_start  = 1'b0;
        i_cmd_valid    = 1'b0;
        i_cmd_model_id = '0;
        i_cmd_last     = 1'b0;
        i_model_loaded = 1'b0;
        i_tp_ready     = 1'b0;
        i_tp_done      = 1'b0;
        i_triangle_dv  = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        clearInputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cacheValid = 1'b0;
        loadQ.delete();
        tpQ.delete();
        frameQ.delete();
        #1;
    endtask

    task automatic waitReady(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (o_ready === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
            #1;
        end
    endtask

    // Frame-level model: cache lookups, per-draw outcome, saturating tally.
    task automatic pushExpected();
        int        draws;
        int        tris;
        bit        to;
        int        window;
        int        lastK;
        frameExp_t f;
        draws  = 0;
        tris   = frmSat;
        to     = 1'b0;
        window = TO - 1;
        for (int i = 0; i < frmN; i++) begin
            if (!cacheValid || cacheId != frmIds[i]) begin
                loadQ.push_back(frmIds[i]);
                cacheValid = 1'b1;
                cacheId    = frmIds[i];
            end
            tpQ.push_back(frmIds[i]);
            if (frmDelay[i] >= 0 && frmDelay[i] < window) begin
                lastK = frmDelay[i];
                draws = draws + 1;
            end else begin
                lastK = window - 1;
                to    = 1'b1;
            end
            for (int k = 0; k <= lastK; k++) tris = tris + int'(frmDv[i][k]);
            if (to) begin
                cacheValid = 1'b0;
                break;
            end
        end
        f.draws    = draws % (1 << DW);
        f.tris     = (tris > TRI_MAX) ? TRI_MAX : tris;
        f.timedOut = to;
        frameQ.push_back(f);
    endtask

    // Drives one frame described by the frm* variables, reacting to handshakes.
    task automatic applyStimulus();
        bit ok;
        bit done;
        int endK;
        int pending;
        int seenAt;
        waitReady(ok);
        if (!ok) begin
            failNow("ready_before_frame");
            doReset();
        end
        pushExpected();

        @(negedge clk);
        i_frame_start = 1'b1;
        i_triangle_dv = 1'($urandom_range(0, 1));
        #1;
        checkOutput("ready_in_idle", o_ready, 1);
        @(negedge clk);
        i_frame_start = 1'b0;
        i_triangle_dv = 1'b0;
        #1;
        checkOutput("cmd_ready_after_start", o_cmd_ready, 1);
        checkOutput("draw_count_cleared", o_draw_count, 0);
        checkOutput("triangle_count_cleared", o_triangle_count, 0);
        checkOutput("timeout_cleared", o_timeout, 0);

        for (int i = 0; i < frmN; i++) begin
            ok = 1'b0;
            for (int c = 0; c < 64; c++) begin
                if (o_cmd_ready === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
                #1;
            end
            if (!ok) begin
                failNow("cmd_ready_wait");
                return;
            end
            i_cmd_valid    = 1'b1;
            i_cmd_model_id = frmIds[i];
            i_cmd_last     = (i == frmN - 1);

            pending = -1;
            seenAt  = -1;
            ok      = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                i_cmd_valid    = 1'b0;
                i_triangle_dv  = 1'b0;
                i_model_loaded = (pending == 0);
                if (pending >= 0) pending--;
                if (c < frmTpLow) i_tp_ready = 1'b0;
                else if (frmTpLow > 0) i_tp_ready = 1'b1;
                else i_tp_ready = ($urandom_range(0, 3) != 0);
                #1;
                if (o_model_load === 1'b1) begin
                    if (frmSat > 0 && i == 0) begin
                        for (int s = 0; s < frmSat; s++) begin
                            @(negedge clk);
                            i_triangle_dv = 1'b1;
                        end
                        #1;
                        checkOutput("triangle_count_saturated", o_triangle_count,
                                    ((frmSat - 1) > TRI_MAX) ? TRI_MAX : (frmSat - 1));
                    end
                    pending = $urandom_range(0, 4);
                end
                if (o_tp_start === 1'b1) begin
                    ok     = 1'b1;
                    seenAt = c;
                    break;
                end
            end
            if (!ok) begin
                failNow("tp_start_wait");
                return;
            end
            if (frmTpLow > 0) checkOutput("tp_start_first_ready_cycle", seenAt, frmTpLow);

            done = (frmDelay[i] >= 0) && (frmDelay[i] <= TO - 2);
            endK = done ? frmDelay[i] : TO - 2;
            for (int k = 0; k <= endK; k++) begin
                @(negedge clk);
                i_tp_ready    = 1'($urandom_range(0, 1));
                i_tp_done     = done && (k == endK);
                i_triangle_dv = frmDv[i][k];
                i_frame_start = ($urandom_range(0, 7) == 0);
                #1;
                if (k == 0) checkOutput("tp_start_single_cycle", o_tp_start, 0);
            end
            @(negedge clk);
            i_tp_done     = 1'b0;
            i_triangle_dv = 1'b0;
            i_frame_start = 1'b0;
            #1;
            if (!done || i == frmN - 1) begin
                checkOutput("frame_done_timing", o_frame_done, 1);
                @(negedge clk);
                #1;
                checkOutput("ready_after_frame", o_ready, 1);
                return;
            end
            checkOutput("cmd_ready_after_done", o_cmd_ready, 1);
        end
    endtask

    // Reset while waiting for a model load: no frame completion, cache lost.
    task automatic resetInWaitLoad(output logic [MW-1:0] id);
        bit ok;
        waitReady(ok);
        if (!ok) begin
            failNow("ready_before_reset_test");
            doReset();
        end
        id = cacheValid ? (cacheId + 1'b1) : MW'(7);
        loadQ.push_back(id);
        @(negedge clk);
        i_frame_start = 1'b1;
        @(negedge clk);
        i_frame_start = 1'b0;
        #1;
        checkOutput("reset_test_cmd_ready", o_cmd_ready, 1);
        i_cmd_valid    = 1'b1;
        i_cmd_model_id = id;
        i_cmd_last     = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            i_cmd_valid = 1'b0;
            #1;
            if (o_model_load === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) failNow("reset_test_load_wait");
        @(negedge clk);
        i_frame_start = 1'b1;
        #1;
        @(negedge clk);
        i_frame_start = 1'b0;
        #1;
        checkOutput("busy_frame_start_ignored", o_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("reset_to_idle", o_ready, 1);
        checkOutput("reset_model_select", o_model_select, 0);
        checkOutput("reset_no_frame_done", o_frame_done, 0);
        rst = 1'b0;
        cacheValid = 1'b0;
    endtask

    task automatic setFrame(input int n, input int tpLow, input int sat);
        frmN     = n;
        frmTpLow = tpLow;
        frmSat   = sat;
        for (int i = 0; i < 8; i++) begin
            frmIds[i]   = '0;
            frmDelay[i] = 0;
            frmDv[i]    = $urandom;
        end
    endtask

    initial begin
        #(10 * 95000);
        $display("[TB] FAIL global_timeout: got simulation still running, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic [MW-1:0] rid;
        rst = 1'b1;
        clearInputs();
        doReset();

        checkOutput("idle_ready", o_ready, 1);
        checkOutput("idle_cmd_ready", o_cmd_ready, 0);
        checkOutput("idle_model_load", o_model_load, 0);
        checkOutput("idle_frame_done", o_frame_done, 0);
        checkOutput("idle_tp_start", o_tp_start, 0);
        checkOutput("idle_model_select", o_model_select, 0);
        checkOutput("idle_draw_count", o_draw_count, 0);
        checkOutput("idle_triangle_count", o_triangle_count, 0);
        checkOutput("idle_timeout", o_timeout, 0);

        setFrame(1, 0, 0);
        frmIds[0] = 3; frmDelay[0] = 10;
        applyStimulus();

        setFrame(3, 0, 0);
        frmIds[0] = 2; frmIds[1] = 2; frmIds[2] = 5;
        frmDelay[0] = 4; frmDelay[1] = 0; frmDelay[2] = 7;
        applyStimulus();

        setFrame(1, 10, 0);
        frmIds[0] = 5; frmDelay[0] = 3;
        applyStimulus();

        setFrame(2, 0, 0);
        frmIds[0] = 6; frmIds[1] = 7;
        frmDelay[0] = -1; frmDelay[1] = 3;
        applyStimulus();

        setFrame(1, 0, 0);
        frmIds[0] = 6; frmDelay[0] = TO - 2;
        applyStimulus();

        setFrame(1, 0, 70000);
        frmIds[0] = 9; frmDelay[0] = 2;
        applyStimulus();

        setFrame(1, 0, 0);
        frmIds[0] = 9; frmDelay[0] = 1;
        applyStimulus();

        resetInWaitLoad(rid);
        setFrame(1, 0, 0);
        frmIds[0] = rid; frmDelay[0] = 5;
        applyStimulus();

        for (int f = 0; f < 40; f++) begin
            setFrame($urandom_range(1, 4), 0, 0);
            for (int i = 0; i < frmN; i++) begin
                int sel;
                frmIds[i] = MW'($urandom_range(0, 3));
                sel = $urandom_range(0, 7);
                if (sel == 0) frmDelay[i] = -1;
                else if (sel == 1) frmDelay[i] = TO - 2;
                else if (sel == 2) frmDelay[i] = $urandom_range(TO - 1, 24);
                else frmDelay[i] = $urandom_range(0, TO - 3);
            end
            applyStimulus();
        end

        repeat (4) @(negedge clk);
        #3;
        checkOutput("load_queue_drained", loadQ.size(), 0);
        checkOutput("tp_queue_drained", tpQ.size(), 0);
        checkOutput("frame_queue_drained", frameQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
